fix_addsub_pipe: RTL and testbench
==================================

Name: fix_addsub_pipe

Overview:
- Pipelined, parametrised sign-magnitude fixed-point adder/subtractor with a built-in accumulator.
- Number format: sign bit plus (N-1)-bit magnitude, of which Q bits are fractional.
- Adds over the combinational fixed-point adder: valid/ready flow control, saturation with overflow reporting, subtract/accumulate/clear modes, canonical zero.
- Sits in the datapath between operand sources and downstream filters/accumulating stages.

Parameters:
- N, 16, total word width including sign bit (min 4).
- Q, 8, fractional bits within the magnitude (Q <= N-2; informational only, arithmetic is format-agnostic).
- CNT_W, 8, width of the saturating overflow event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  N  operand A, sign-magnitude.
- in_b  input  N  operand B, sign-magnitude (ignored in ACC/CLR).
- in_mode  input  2  00 ADD (A+B), 01 SUB (A-B), 10 ACC (acc+A), 11 CLR.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_c  output  N  result, sign-magnitude.
- out_ovf  output  1  result was saturated.
- acc_val  output  N  current accumulator contents.
- ovf_cnt  output  CNT_W  count of saturated results.

Behaviour:
- Reset (async, rst_n=0): all pipeline valids 0; out_c, acc_val, ovf_cnt = 0; out_ovf = 0; in_ready = 1 once rst_n deasserts.
- Reset mid-operation discards all in-flight beats; no output is produced for them.
- Handshake: a beat transfers when valid && ready on a rising edge.
  - Stage 1 (S1) registers operands and mode, with SUB converted to ADD by inverting B's sign.
  - Stage 2 (S2) is the output register.
- Flow control:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load.
  - Full throughput, one beat per cycle; latency exactly 2 cycles from input transfer to out_valid with out_ready held high.
  - Stalled outputs (out_valid=1, out_ready=0) hold out_c/out_ovf stable.
  - Beats are never dropped or reordered.
- Arithmetic, computed combinationally from S1 into S2:
  - Operand Y = B' in ADD/SUB, acc_val in ACC. B' is B with its sign inverted in SUB.
  - Equal signs: magnitude = |X|+|Y| in N bits, sign = common sign.
  - Differing signs: magnitude = larger minus smaller; sign = sign of the larger magnitude.
  - Equal magnitudes with differing signs give +0.
  - Magnitude carry-out (overflow): saturate magnitude to all ones (2^(N-1)-1), keep sign, out_ovf = 1.
  - Canonical zero: a result with zero magnitude is always emitted as +0 (0x...0), including when an input is -0.
  - CLR: out_c = 0, out_ovf = 0.
- Accumulator:
  - Updated only on s2_load.
  - ACC: acc_val <= result.
  - CLR: acc_val <= 0.
  - ADD/SUB: acc_val unchanged.
  - acc_val is read at the S1->S2 transfer, so back-to-back ACC beats chain correctly with no hazard.
- ovf_cnt: increments on each s2_load whose result saturates; sticks at 2^CNT_W-1; cleared only by reset or CLR. Clearing takes priority; a CLR beat never overflows.
- Simultaneous S2 drain and S1 refill in one cycle is legal and required for full throughput.

Test Plan (N=16, Q=8, 1.0=0x0100):
- ADD 0x0180 + 0x8100, out_ready=1 -> out_c=0x0080 (+0.5), out_ovf=0, out_valid exactly 2 cycles after transfer; SUB 0x0100 - 0x8080 -> 0x0180.
- Cancellation and zero:
  - ADD 0x8100 + 0x0100 -> 0x0000 (not 0x8000).
  - SUB 0x0100 - 0x0100 -> 0x0000.
  - ADD 0x8000 + 0x8000 -> 0x0000.
- Saturation:
  - ADD 0x7F00 + 0x0200 -> 0x7FFF, out_ovf=1, ovf_cnt=1.
  - ADD 0xFF00 + 0x8200 -> 0xFFFF, ovf_cnt=2.
  - Force 300 overflows -> ovf_cnt holds 0xFF.
- Accumulate: CLR, then ACC 0x0100 three times back-to-back -> outputs 0x0000, 0x0100, 0x0200, 0x0300 on consecutive cycles, acc_val=0x0300; then ACC 0x8400 -> 0x8100.
- Backpressure: 6 beats offered continuously, out_ready low for cycles 3-7 -> in_ready drops after 2 beats accepted during stall; all 6 results emerge in order, out_c stable while stalled.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight and acc_val=0x0300 -> out_valid=0, acc_val=0, ovf_cnt=0 immediately (async); next accepted beat yields a correct result 2 cycles later.

Source files
------------

// File: rtl/fix_addsub_pipe.sv
// Two-stage sign-magnitude fixed-point add/sub/accumulate pipeline with
// valid/ready flow control, saturation, canonical zero and an overflow counter.
module fix_addsub_pipe #(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_c,
    output logic             out_ovf,
    output logic [N-1:0]     acc_val,
    output logic [CNT_W-1:0] ovf_cnt
);

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_t;

    if (N < 4 || Q > N - 2) begin : g_param_check
        $error("fix_addsub_pipe: invalid N/Q combination");
    end

    logic         s1_valid;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;
    mode_t        s1_mode;
    logic         s2_load;
    logic         in_fire;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    // SUB is folded into ADD here by flipping B's sign, so S2 only sees ADD/ACC/CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_ADD;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            if (mode_t'(in_mode) == MODE_SUB) begin
                s1_b    <= {~in_b[N-1], in_b[N-2:0]};
                s1_mode <= MODE_ADD;
            end else begin
                s1_b    <= in_b;
                s1_mode <= mode_t'(in_mode);
            end
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    logic [N-1:0] y;
    logic [N-1:0] mag_sum;
    logic [N-2:0] res_mag;
    logic         res_sign;
    logic         res_ovf;
    logic [N-1:0] res_c;

    always_comb begin
        y        = (s1_mode == MODE_ACC) ? acc_val : s1_b;
        mag_sum  = {1'b0, s1_a[N-2:0]} + {1'b0, y[N-2:0]};
        res_mag  = '0;
        res_sign = 1'b0;
        res_ovf  = 1'b0;
        if (s1_a[N-1] == y[N-1]) begin
            res_sign = s1_a[N-1];
            if (mag_sum[N-1]) begin
                res_mag = '1;
                res_ovf = 1'b1;
            end else begin
                res_mag = mag_sum[N-2:0];
            end
        end else if (s1_a[N-2:0] >= y[N-2:0]) begin
            res_sign = s1_a[N-1];
            res_mag  = s1_a[N-2:0] - y[N-2:0];
        end else begin
            res_sign = y[N-1];
            res_mag  = y[N-2:0] - s1_a[N-2:0];
        end
        // Zero magnitude is always emitted as +0, whatever the operand signs.
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
        if (s1_mode == MODE_CLR) begin
            res_mag  = '0;
            res_sign = 1'b0;
            res_ovf  = 1'b0;
        end
        res_c = {res_sign, res_mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_ovf   <= 1'b0;
            acc_val   <= '0;
            ovf_cnt   <= '0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                out_c     <= res_c;
                out_ovf   <= res_ovf;
                if (s1_mode == MODE_ACC || s1_mode == MODE_CLR) begin
                    acc_val <= res_c;
                end
                if (s1_mode == MODE_CLR) begin
                    ovf_cnt <= '0;
                end else if (res_ovf && ovf_cnt != '1) begin
                    ovf_cnt <= ovf_cnt + CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fix_addsub_pipe.sv
// Scoreboard bench for fix_addsub_pipe: an integer reference model predicts each
// result at input transfer; the output monitor pops and compares in order.
module tb_fix_addsub_pipe;

    localparam int N     = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic [1:0]       in_mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N-1:0]     out_c;
    logic             out_ovf;
    logic [N-1:0]     acc_val;
    logic [CNT_W-1:0] ovf_cnt;

    fix_addsub_pipe #(.N(N), .Q(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_ovf(out_ovf),
        .acc_val(acc_val), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [N:0] sb[$];
    int out_cyc[$];
    logic [N-1:0] m_acc = '0;
    int m_cnt = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int sm2int(input logic [N-1:0] v);
        int mag;
        mag = int'(v[N-2:0]);
        return v[N-1] ? -mag : mag;
    endfunction

    function automatic logic [N-1:0] int2sm(input int v);
        logic [N-1:0] r;
        if (v < 0) r = {1'b1, (N-1)'(-v)};
        else       r = {1'b0, (N-1)'(v)};
        return r;
    endfunction

    // Reference: exact integer sum, then clamp to +/-(2^(N-1)-1).
    task automatic model_push(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] m);
        int s;
        int lim;
        logic ovf;
        logic [N-1:0] c;
        lim = (1 << (N - 1)) - 1;
        ovf = 1'b0;
        if (m == 2'b11) begin
            c = '0;
            m_acc = '0;
            m_cnt = 0;
        end else begin
            case (m)
                2'b00:   s = sm2int(a) + sm2int(b);
                2'b01:   s = sm2int(a) - sm2int(b);
                default: s = sm2int(a) + sm2int(m_acc);
            endcase
            if (s > lim) begin s = lim; ovf = 1'b1; end
            if (s < -lim) begin s = -lim; ovf = 1'b1; end
            c = int2sm(s);
            if (m == 2'b10) m_acc = c;
            if (ovf && m_cnt < 255) m_cnt++;
        end
        sb.push_back({ovf, c});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) model_push(in_a, in_b, in_mode);
            if (out_valid && out_ready) begin
                checks++;
                out_cyc.push_back(cycle);
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got c=%h ovf=%b, expected no output", out_c, out_ovf);
                end else begin
                    logic [N:0] e;
                    e = sb.pop_front();
                    if ({out_ovf, out_c} !== e) begin
                        errors++;
                        $display("FAIL sb_result: got c=%h ovf=%b, expected c=%h ovf=%b",
                                 out_c, out_ovf, e[N-1:0], e[N]);
                    end
                end
            end
        end
    end

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] m);
        logic ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected 1");
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #2;
            done = (sb.size() == 0) && !out_valid;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic check_state(input string name);
        checks++;
        if (acc_val !== m_acc || ovf_cnt !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL %s: got acc=%h cnt=%0d, expected acc=%h cnt=%0d",
                     name, acc_val, ovf_cnt, m_acc, m_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_c !== '0 || out_ovf !== 1'b0 || acc_val !== '0 || ovf_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b c=%h o=%b acc=%h cnt=%0d, expected all 0",
                     out_valid, out_c, out_ovf, acc_val, ovf_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_latency();
        send(16'h0180, 16'h8100, 2'b00);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: got out_valid=%b one cycle after transfer, expected 0", out_valid);
        end
        @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b1 || out_c !== 16'h0080) begin
            errors++;
            $display("FAIL lat_result: got v=%b c=%h, expected v=1 c=0080", out_valid, out_c);
        end
        drain();
    endtask

    task automatic test_arith();
        send(16'h0100, 16'h8080, 2'b01);
        send(16'h8100, 16'h0100, 2'b00);
        send(16'h0100, 16'h0100, 2'b01);
        send(16'h8000, 16'h8000, 2'b00);
        send(16'h8000, 16'h0000, 2'b01);
        send(16'h0250, 16'h8300, 2'b00);
        send(16'h8001, 16'h0003, 2'b01);
        drain();
        check_state("arith_state");
    endtask

    task automatic test_saturation();
        send(16'h7F00, 16'h0200, 2'b00);
        drain();
        check_state("sat_cnt1");
        send(16'hFF00, 16'h8200, 2'b00);
        drain();
        check_state("sat_cnt2");
        for (int i = 0; i < 300; i++) send(16'h7FFF, 16'h0001, 2'b00);
        drain();
        checks++;
        if (ovf_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL sat_stick: got %h, expected FF", ovf_cnt);
        end
        send(16'h0000, 16'h0000, 2'b11);
        drain();
        check_state("sat_clear");
    endtask

    task automatic test_accumulate();
        out_cyc.delete();
        send(16'h1234, 16'h5678, 2'b11);
        send(16'h0100, 16'h7FFF, 2'b10);
        send(16'h0100, 16'h7FFF, 2'b10);
        send(16'h0100, 16'h7FFF, 2'b10);
        drain();
        checks++;
        if (acc_val !== 16'h0300) begin
            errors++;
            $display("FAIL acc_value: got %h, expected 0300", acc_val);
        end
        checks++;
        if (out_cyc.size() != 4 || out_cyc[3] - out_cyc[0] != 3) begin
            errors++;
            $display("FAIL acc_b2b: got %0d outputs, expected 4 on consecutive cycles", out_cyc.size());
        end
        send(16'h8400, 16'h0000, 2'b10);
        drain();
        checks++;
        if (acc_val !== 16'h8100) begin
            errors++;
            $display("FAIL acc_neg: got %h, expected 8100", acc_val);
        end
    endtask

    task automatic test_backpressure();
        logic saw_stall;
        logic have_prev;
        logic [N-1:0] prev;
        saw_stall = 1'b0;
        have_prev = 1'b0;
        prev = '0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(16'(i * 16'h0010), 16'h8005, 2'b00);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (in_valid && !in_ready) saw_stall = 1'b1;
                    if (out_valid) begin
                        if (have_prev) begin
                            checks++;
                            if (out_c !== prev) begin
                                errors++;
                                $display("FAIL bp_stable: got %h, expected %h", out_c, prev);
                            end
                        end
                        prev = out_c;
                        have_prev = 1'b1;
                    end
                    @(posedge clk);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (!saw_stall) begin
            errors++;
            $display("FAIL bp_ready: got in_ready never low during stall, expected low");
        end
    endtask

    task automatic test_reset_midstream();
        send(16'h0000, 16'h0000, 2'b11);
        for (int i = 0; i < 3; i++) send(16'h0100, 16'h0000, 2'b10);
        send(16'h7F00, 16'h0200, 2'b00);
        drain();
        check_state("rst_pre");
        out_ready = 1'b0;
        send(16'h0100, 16'h0100, 2'b00);
        send(16'h0200, 16'h0100, 2'b00);
        #1;
        rst_n = 1'b0;
        sb.delete();
        m_acc = '0;
        m_cnt = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || acc_val !== '0 || ovf_cnt !== '0) begin
            errors++;
            $display("FAIL rst_async: got v=%b acc=%h cnt=%0d, expected 0/0/0", out_valid, acc_val, ovf_cnt);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        send(16'h0300, 16'h8100, 2'b00);
        @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b1 || out_c !== 16'h0200) begin
            errors++;
            $display("FAIL rst_recover: got v=%b c=%h, expected v=1 c=0200", out_valid, out_c);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_saturation();
        test_accumulate();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
